// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bus access with byte enables, lane replication and load extension.
// Define MISALIGN_EXC_EN to trap misaligned requests instead of silently aligning them down.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [DATA_W-1:0]    req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [DATA_W-1:0]    rsp_rdata_o,
    output logic                 bus_valid_o,
    input  logic                 bus_ready_i,
    output logic                 bus_we_o,
    output logic [ADDR_W-1:0]    bus_addr_o,
    output logic [DATA_W/8-1:0]  bus_be_o,
    output logic [DATA_W-1:0]    bus_wdata_o,
    input  logic                 bus_rvalid_i,
    input  logic [DATA_W-1:0]    bus_rdata_i
`ifdef MISALIGN_EXC_EN
    ,
    output logic                 misalign_exc_o
`endif
);
    localparam int NB = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d, uns_q, uns_d, rsp_q, rsp_d;
    logic [OFS_W-1:0]  aoff_q, aoff_d;
    logic [NB-1:0]     be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

    logic [1:0]        s;
    logic [OFS_W-1:0]  off, amask, aoff;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wrep, sh, keep, ext;
    logic [6:0]        kw;
    logic              hs, mis;

    assign s     = (DATA_W == 32 && req_size_i == 2'd3) ? 2'd2 : req_size_i;
    assign off   = req_addr_i[OFS_W-1:0];
    assign amask = OFS_W'((1 << s) - 1);
    assign aoff  = off & ~amask;
    assign be    = NB'((1 << (1 << s)) - 1) << aoff;
    assign hs    = req_valid_i && req_ready_o;

    // Each lane takes the byte of the access group it falls in.
    genvar i;
    for (i = 0; i < NB; i++) begin : g_rep
        assign wrep[8*i +: 8] = req_wdata_i[{OFS_W'(i) & amask, 3'b000} +: 8];
    end

    // keep masks the access width; its top bit selects the sign for extension.
    assign sh   = bus_rdata_i >> {aoff_q, 3'b000};
    assign kw   = 7'd8 << size_q;
    assign keep = ~({DATA_W{1'b1}} << kw);
    assign ext  = (sh & keep) | ((!uns_q && |(sh & (keep ^ (keep >> 1)))) ? ~keep : '0);

`ifdef MISALIGN_EXC_EN
    logic exc_q;
    assign mis = off != aoff;
    always_ff @(posedge clk_i) exc_q <= !reset_i && hs && mis;
    assign misalign_exc_o = exc_q;
`else
    assign mis = 1'b0;
`endif

    assign req_ready_o = state_q == IDLE && !reset_i;
    assign bus_valid_o = state_q == REQ;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign rsp_valid_o = rsp_q;
    assign rsp_rdata_o = rdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        aoff_d  = aoff_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rsp_d   = 1'b0;
        case (state_q)
            IDLE: if (hs) begin
                addr_d  = {req_addr_i[ADDR_W-1:OFS_W], OFS_W'(0)};
                size_d  = s;
                we_d    = req_we_i;
                uns_d   = req_unsigned_i;
                aoff_d  = aoff;
                be_d    = be;
                wdata_d = wrep;
                state_d = mis ? IDLE : REQ;
                rsp_d   = mis;
                rdata_d = mis ? '0 : rdata_q;
            end
            REQ: if (bus_ready_i) begin
                state_d = we_q ? IDLE : WAIT;
                rsp_d   = we_q;
                rdata_d = we_q ? '0 : rdata_q;
            end
            WAIT: if (bus_rvalid_i) begin
                state_d = IDLE;
                rsp_d   = 1'b1;
                rdata_d = ext;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            aoff_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            aoff_q  <= aoff_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit at DATA_W=32 and DATA_W=64.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic        a_rsp_valid, a_bus_valid, a_bus_ready, a_bus_we, a_bus_rvalid;
  logic [3:0]  a_bus_be;
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_bus_addr;
  logic [63:0] b_req_wdata, b_rsp_rdata, b_bus_wdata, b_bus_rdata;
  logic        b_rsp_valid, b_bus_valid, b_bus_ready, b_bus_we, b_bus_rvalid;
  logic [7:0]  b_bus_be;
`ifdef MISALIGN_EXC_EN
  logic        a_exc, b_exc;
`endif
  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_a (
`ifdef MISALIGN_EXC_EN
    .misalign_exc_o(a_exc),
`endif
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_size_i(a_req_size), .req_unsigned_i(a_req_unsigned), .req_addr_i(a_req_addr),
    .req_wdata_i(a_req_wdata), .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata),
    .bus_valid_o(a_bus_valid), .bus_ready_i(a_bus_ready), .bus_we_o(a_bus_we),
    .bus_addr_o(a_bus_addr), .bus_be_o(a_bus_be), .bus_wdata_o(a_bus_wdata),
    .bus_rvalid_i(a_bus_rvalid), .bus_rdata_i(a_bus_rdata)
  );
  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_b (
`ifdef MISALIGN_EXC_EN
    .misalign_exc_o(b_exc),
`endif
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_size_i(b_req_size), .req_unsigned_i(b_req_unsigned), .req_addr_i(b_req_addr),
    .req_wdata_i(b_req_wdata), .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
    .bus_valid_o(b_bus_valid), .bus_ready_i(b_bus_ready), .bus_we_o(b_bus_we),
    .bus_addr_o(b_bus_addr), .bus_be_o(b_bus_be), .bus_wdata_o(b_bus_wdata),
    .bus_rvalid_i(b_bus_rvalid), .bus_rdata_i(b_bus_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req_a(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] ad, input logic [31:0] wd);
    a_req_valid = 1'b1; a_req_we = we; a_req_size = sz; a_req_unsigned = uns;
    a_req_addr = ad; a_req_wdata = wd;
  endtask
  task automatic req_b(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] ad, input logic [63:0] wd);
    b_req_valid = 1'b1; b_req_we = we; b_req_size = sz; b_req_unsigned = uns;
    b_req_addr = ad; b_req_wdata = wd;
  endtask
  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_unsigned = 0;
    a_req_addr = 0; a_req_wdata = 0; a_bus_ready = 0; a_bus_rvalid = 0; a_bus_rdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_unsigned = 0;
    b_req_addr = 0; b_req_wdata = 0; b_bus_ready = 0; b_bus_rvalid = 0; b_bus_rdata = 0;
    tick; tick;
    chk("rst_req_ready_a", a_req_ready, 1'b0);
    chk("rst_req_ready_b", b_req_ready, 1'b0);
    chk("rst_bus_valid", a_bus_valid, 1'b0);
    chk("rst_rsp_valid", a_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    chk("rst_bus_be_b", b_bus_be, 8'h00);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", a_req_ready, 1'b1);
    req_a(1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000AB);
    tick; a_req_valid = 1'b0;
    chk("sb_bus_valid", a_bus_valid, 1'b1);
    chk("sb_be", a_bus_be, 4'b1000);
    chk("sb_wdata", a_bus_wdata, 32'hABABABAB);
    chk("sb_addr", a_bus_addr, 32'h00001000);
    chk("sb_we", a_bus_we, 1'b1);
    chk("sb_stall", a_req_ready, 1'b0);
    a_bus_ready = 1'b1; tick; a_bus_ready = 1'b0;
    chk("sb_rsp_valid", a_rsp_valid, 1'b1);
    chk("sb_rsp_rdata", a_rsp_rdata, 32'h0);
    chk("sb_bus_idle", a_bus_valid, 1'b0);
    tick;
    chk("sb_rsp_pulse", a_rsp_valid, 1'b0);
    req_a(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0);
    tick; a_req_valid = 1'b0;
    chk("lh_be", a_bus_be, 4'b1100);
    chk("lh_we", a_bus_we, 1'b0);
    chk("lh_addr", a_bus_addr, 32'h00002000);
    a_bus_ready = 1'b1; tick; a_bus_ready = 1'b0;
    chk("lh_wait_valid", a_bus_valid, 1'b0);
    chk("lh_wait_rsp", a_rsp_valid, 1'b0);
    a_bus_rvalid = 1'b1; a_bus_rdata = 32'h80011234;
    tick; a_bus_rvalid = 1'b0;
    chk("lh_rsp_valid", a_rsp_valid, 1'b1);
    chk("lh_signed", a_rsp_rdata, 32'hFFFF8001);
    chk("lh_b2b_ready", a_req_ready, 1'b1);
    req_a(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0);
    tick; a_req_valid = 1'b0;
    chk("lhu_rsp_fall", a_rsp_valid, 1'b0);
    chk("lhu_hold", a_rsp_rdata, 32'hFFFF8001);
    chk("lhu_bus_valid", a_bus_valid, 1'b1);
    a_bus_ready = 1'b1; tick; a_bus_ready = 1'b0;
    a_bus_rvalid = 1'b1; tick; a_bus_rvalid = 1'b0;
    chk("lhu_rsp_valid", a_rsp_valid, 1'b1);
    chk("lhu_unsigned", a_rsp_rdata, 32'h00008001);
    tick;
    a_bus_rvalid = 1'b1; a_bus_ready = 1'b1;
    tick; a_bus_rvalid = 1'b0; a_bus_ready = 1'b0;
    chk("idle_rvalid_ignored", a_rsp_valid, 1'b0);
    chk("idle_ready_ignored", a_bus_valid, 1'b0);
    chk("idle_rdata_hold", a_rsp_rdata, 32'h00008001);
    req_a(1'b0, 2'd0, 1'b1, 32'h4001, 32'h00000011);
    tick;
    req_a(1'b1, 2'd2, 1'b0, 32'h5000, 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      chk("stall_bus_valid", a_bus_valid, 1'b1);
      chk("stall_addr", a_bus_addr, 32'h00004000);
      chk("stall_be", a_bus_be, 4'b0010);
      chk("stall_wdata", a_bus_wdata, 32'h11111111);
      chk("stall_req_ready", a_req_ready, 1'b0);
      tick;
    end
    a_bus_ready = 1'b1; tick; a_bus_ready = 1'b0;
    chk("stall_wait_ready", a_req_ready, 1'b0);
    a_bus_rvalid = 1'b1; a_bus_rdata = 32'h0000A500;
    tick; a_bus_rvalid = 1'b0;
    chk("lbu_rsp_valid", a_rsp_valid, 1'b1);
    chk("lbu_rdata", a_rsp_rdata, 32'h000000A5);
    chk("lbu_b2b_ready", a_req_ready, 1'b1);
    tick; a_req_valid = 1'b0;
    chk("sw2_bus_valid", a_bus_valid, 1'b1);
    chk("sw2_addr", a_bus_addr, 32'h00005000);
    chk("sw2_be", a_bus_be, 4'b1111);
    chk("sw2_wdata", a_bus_wdata, 32'hCAFEF00D);
    a_bus_ready = 1'b1; tick; a_bus_ready = 1'b0;
    chk("sw2_rsp_valid", a_rsp_valid, 1'b1);
    chk("sw2_rdata_cleared", a_rsp_rdata, 32'h0);
    req_a(1'b1, 2'd3, 1'b0, 32'h7000, 32'h12345678);
    tick; a_req_valid = 1'b0;
    chk("clamp_be", a_bus_be, 4'b1111);
    chk("clamp_wdata", a_bus_wdata, 32'h12345678);
    a_bus_ready = 1'b1; tick; a_bus_ready = 1'b0;
    chk("clamp_rsp", a_rsp_valid, 1'b1);
    req_a(1'b0, 2'd2, 1'b0, 32'h3002, 32'h0);
    tick; a_req_valid = 1'b0;
`ifdef MISALIGN_EXC_EN
    chk("mis_bus_valid", a_bus_valid, 1'b0);
    chk("mis_exc", a_exc, 1'b1);
    chk("mis_rsp_valid", a_rsp_valid, 1'b1);
    chk("mis_rdata", a_rsp_rdata, 32'h0);
    tick;
    chk("mis_exc_pulse", a_exc, 1'b0);
    chk("mis_no_bus", a_bus_valid, 1'b0);
    chk("mis_rsp_pulse", a_rsp_valid, 1'b0);
`else
    chk("mis_bus_valid", a_bus_valid, 1'b1);
    chk("mis_addr", a_bus_addr, 32'h00003000);
    chk("mis_be", a_bus_be, 4'b1111);
    a_bus_ready = 1'b1; tick; a_bus_ready = 1'b0;
    a_bus_rvalid = 1'b1; a_bus_rdata = 32'h12345678;
    tick; a_bus_rvalid = 1'b0;
    chk("mis_rsp_valid", a_rsp_valid, 1'b1);
    chk("mis_rdata", a_rsp_rdata, 32'h12345678);
`endif
    req_a(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0);
    tick; a_req_valid = 1'b0;
    a_bus_ready = 1'b1; tick; a_bus_ready = 1'b0;
    rst = 1'b1; #1;
    chk("rstw_req_ready", a_req_ready, 1'b0);
    tick;
    rst = 1'b0; a_bus_rvalid = 1'b1; a_bus_rdata = 32'hFFFFFFFF; #1;
    chk("rstw_bus_valid", a_bus_valid, 1'b0);
    chk("rstw_rsp_valid", a_rsp_valid, 1'b0);
    chk("rstw_req_ready_up", a_req_ready, 1'b1);
    tick; a_bus_rvalid = 1'b0;
    chk("rstw_no_rsp", a_rsp_valid, 1'b0);
    chk("rstw_rdata", a_rsp_rdata, 32'h0);
    req_b(1'b0, 2'd2, 1'b1, 32'h00000104, 64'h0);
    tick; b_req_valid = 1'b0;
    chk("b_lwu_bus_valid", b_bus_valid, 1'b1);
    chk("b_lwu_be", b_bus_be, 8'hF0);
    chk("b_lwu_addr", b_bus_addr, 32'h00000100);
    b_bus_ready = 1'b1; tick; b_bus_ready = 1'b0;
    b_bus_rvalid = 1'b1; b_bus_rdata = 64'hDEADBEEF_01234567;
    tick; b_bus_rvalid = 1'b0;
    chk("b_lwu_rsp_valid", b_rsp_valid, 1'b1);
    chk("b_lwu_rdata", b_rsp_rdata, 64'h00000000_DEADBEEF);
    req_b(1'b0, 2'd0, 1'b0, 32'h00000107, 64'h0);
    tick; b_req_valid = 1'b0;
    chk("b_lb_be", b_bus_be, 8'h80);
    b_bus_ready = 1'b1; tick; b_bus_ready = 1'b0;
    b_bus_rvalid = 1'b1; tick; b_bus_rvalid = 1'b0;
    chk("b_lb_rdata", b_rsp_rdata, 64'hFFFFFFFF_FFFFFFDE);
    req_b(1'b1, 2'd3, 1'b0, 32'h00000108, 64'h11223344_55667788);
    tick; b_req_valid = 1'b0;
    chk("b_sd_be", b_bus_be, 8'hFF);
    chk("b_sd_wdata", b_bus_wdata, 64'h11223344_55667788);
    chk("b_sd_addr", b_bus_addr, 32'h00000108);
    b_bus_ready = 1'b1; tick; b_bus_ready = 1'b0;
    chk("b_sd_rsp_valid", b_rsp_valid, 1'b1);
    chk("b_sd_rdata", b_rsp_rdata, 64'h0);
    req_b(1'b1, 2'd0, 1'b0, 32'h00000105, 64'h5A);
    tick; b_req_valid = 1'b0;
    chk("b_sb_be", b_bus_be, 8'h20);
    chk("b_sb_wdata", b_bus_wdata, 64'h5A5A5A5A_5A5A5A5A);
    b_bus_ready = 1'b1; tick; b_bus_ready = 1'b0;
    chk("b_sb_rsp_valid", b_rsp_valid, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised data-memory access unit that is the successor to the pipeline's combinational byte-enable decoder.
- Accepts one load/store request from the MEM stage and computes byte enables for byte/half/word/dword sizes at DATA_W=32 or 64.
- Replicates store data across the lanes, issues a valid/ready bus transaction and waits for read data.
- Returns the lane-extracted, sign- or zero-extended load result. It stalls the pipeline through `req_ready` while a transaction is in flight.

Parameters:
- DATA_W, 32, bus/data width; legal values 32 or 64. NB = DATA_W/8 byte lanes; OFS_W = log2(NB).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage presents a request
- req_ready  out  1  unit can accept; low = stall
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned  in  1  load zero-extends (lbu/lhu/lwu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  DATA_W  extended load data; 0 for stores
- bus_valid  out  1  bus request
- bus_ready  in  1  bus accepts request
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  req_addr with low OFS_W bits cleared
- bus_be  out  NB  byte enables
- bus_wdata  out  DATA_W  lane-replicated store data
- bus_rvalid  in  1  read data valid
- bus_rdata  in  DATA_W  full-width read data
- misalign_exc  out  1  one-cycle pulse (MISALIGN_EXC_EN only)

Behaviour:
- Reset: state = IDLE. While reset is high, req_ready=0. All other outputs are 0 in the reset cycle and the cycle after it.
- Size clamp: req_size=3 with DATA_W=32 is treated as word. Call the clamped size s; width = 2^s bytes.
- Offset: off = req_addr[OFS_W-1:0], aligned down to the access width: aoff = off & ~(2^s - 1).
- bus_be: 2^s contiguous ones starting at bit aoff. Examples at DATA_W=32: byte @3 -> 1000; half @2 -> 1100; word -> 1111.
- bus_wdata: the low 2^s bytes of req_wdata, replicated across every lane group.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches addr, size, we, unsigned, be and wdata, then moves to REQ. Request registers change only on a handshake.
- REQ: bus_valid=1. bus_* outputs stay stable until bus_ready.
  - bus_ready on a store -> IDLE, and rsp_valid pulses the next cycle.
  - bus_ready on a load -> WAIT.
- WAIT: bus_valid=0. On bus_rvalid, capture bus_rdata >> (aoff*8), keep the low 2^s bytes, and extend to DATA_W: zero-extend if unsigned, else sign-extend from the top kept bit. Then go to IDLE; rsp_valid and rsp_rdata are presented the next cycle for one cycle.
- rsp_rdata holds its last value after rsp_valid falls. It is 0 after reset and set to 0 by each store completion.
- Latency, with the request accepted in cycle N:
  - bus_valid is asserted in N+1.
  - With bus_ready in N+1, a store's rsp_valid arrives in N+2.
  - With bus_rvalid in N+2, a load's rsp_valid arrives in N+3.
- Back-to-back: the next request is accepted in the same cycle rsp_valid is high, since the state is IDLE then.
- Ignored inputs: bus_rvalid in IDLE or REQ; bus_ready outside REQ.
- Reset mid-transaction: abandon the transaction with no rsp_valid. bus_valid is 0 in the cycle after reset is sampled.

Optional Feature:
- Macro: MISALIGN_EXC_EN.
- Defined:
  - A request with off != aoff is accepted but no bus transaction is issued.
  - misalign_exc and rsp_valid pulse together the cycle after the handshake; rsp_rdata=0.
  - The unit then returns to IDLE.
- Undefined:
  - There is no misalign_exc port.
  - Misaligned addresses are silently aligned down to aoff, and the access proceeds normally.

Test Plan:
- DATA_W=32, store byte addr 0x1003 wdata 0x000000AB, bus_ready in first REQ cycle -> bus_be=1000, bus_wdata=0xABABABAB, bus_addr=0x1000; rsp_valid 2 cycles after accept.
- DATA_W=32, load half signed addr 0x2002, bus_rdata=0x8001_1234, rvalid 1 cycle after bus_ready -> rsp_rdata=0xFFFF8001; same request with req_unsigned=1 -> 0x00008001.
- DATA_W=64, load word unsigned addr 0x...4, bus_rdata=0xDEADBEEF_01234567 -> bus_be=0xF0, rsp_rdata=0x00000000DEADBEEF; dword store -> bus_be=0xFF.
- bus_ready held low 5 cycles -> bus_valid, bus_addr, bus_be and bus_wdata stable throughout; req_ready=0; a second req_valid is not accepted until rsp_valid.
- reset asserted in WAIT, then bus_rvalid arrives -> no rsp_valid; req_ready=1 the cycle after reset drops.
- MISALIGN_EXC_EN defined, load word addr 0x3002 -> bus_valid never rises; misalign_exc=1 and rsp_valid=1 in the cycle after accept. Undefined -> bus_addr=0x3000, bus_be=1111.
